// File: rtl/lfsr_keystream_if.sv
// Keystream port bundle: LFSR control/seed inputs plus the ready/valid word output.
// master = keystream consumer / controller side, slave = generator side.
interface lfsr_keystream_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OUT_BITS = 8
);
  logic [WIDTH-1:0]    taps;
  logic                seed_valid;
  logic [WIDTH-1:0]    seed;
  logic [OUT_BITS-1:0] ks_data;
  logic                ks_valid;
  logic                ks_ready;
  logic                lockup;

  modport master (
    output taps, seed_valid, seed, ks_ready,
    input  ks_data, ks_valid, lockup
  );

  modport slave (
    input  taps, seed_valid, seed, ks_ready,
    output ks_data, ks_valid, lockup
  );
endinterface

// File: rtl/lfsr_keystream.sv
// Galois LFSR keystream generator packing OUT_BITS serial bits per word behind ready/valid.
// Optional macro LFSR_LOCKUP_RECOVER_EN: reload DEFAULT_SEED when the state collapses to zero.
module lfsr_keystream #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      OUT_BITS     = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'('h55)
) (
  input  logic            clk,
  input  logic            rst,
  lfsr_keystream_if.slave ks_if
);

  localparam int unsigned      CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

  // state | meaning
  // FILL  | shifting one keystream bit per cycle into ks_data
  // VALID | word complete, LFSR frozen until the consumer accepts
  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] ks_data_q, ks_data_d;
  logic                do_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      s_q       <= DEFAULT_SEED;
      cnt_q     <= '0;
      ks_data_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      ks_data_q <= ks_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    ks_data_d = ks_data_q;
    do_shift  = 1'b0;

    // A seed load wins over everything; a coincident transfer has already
    // been consumed by the sink, so dropping back to FILL loses nothing.
    if (ks_if.seed_valid) begin
      s_d     = ks_if.seed;
      cnt_d   = '0;
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
          if (s_q == '0) begin
            s_d = DEFAULT_SEED;
          end else begin
            do_shift = 1'b1;
          end
`else
          do_shift = 1'b1;
`endif
        end
        VALID: begin
          if (ks_if.ks_ready) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (do_shift) begin
      ks_data_d[cnt_q] = s_q[0];
      s_d              = s_q[0] ? ((s_q >> 1) ^ ks_if.taps) : (s_q >> 1);
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = VALID;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign ks_if.ks_data  = ks_data_q;
  assign ks_if.ks_valid = (state_q == VALID);
  assign ks_if.lockup   = (s_q == '0);

endmodule
